imem_loader: RTL
================

# imem_loader

Byte-stream program loader that writes the instruction memory the single-cycle RISC-V core fetches from. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake and packs it into 32-bit words. Each word is written into instruction memory, and the core is held in reset until the load completes. It sits beside the core top level: its write port drives the instruction memory, and `core_reset_n` gates the core's reset.

## Interface

Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width. Capacity is 2**ADDR_W words.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: one-cycle request to begin a load. Ignored while `busy`=1.
- `byte_valid`, input, 1: source has a byte on `byte_data`.
- `byte_data`, input, 8: stream byte.
- `byte_ready`, output, 1: loader accepts a byte this cycle.
- `imem_we`, output, 1: instruction-memory write strobe, one cycle per word.
- `imem_waddr`, output, ADDR_W: word address of the write.
- `imem_wdata`, output, 32: word written.
- `core_reset_n`, output, 1: active-low reset to the core.
- `busy`, output, 1: load in progress.
- `done`, output, 1: last load completed successfully.
- `err`, output, 1: last load aborted on an illegal length.

## Operation

- **Stream format:**
  - 16-bit word count N, little-endian (low byte first).
  - Then 4N bytes, each word little-endian: byte 0 goes to `[7:0]`, byte 3 to `[31:24]`.
- **Transfer rule:** a byte transfers on a rising edge where `byte_valid` and `byte_ready` are both 1. `byte_ready` is decoded from the state register only, never from `byte_valid`.
- **Reset values:**
  - State: IDLE.
  - Outputs: `byte_ready`=0, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `core_reset_n`=0, `busy`=0, `done`=0, `err`=0.
- **States and transitions:**
  - IDLE: `start` → LEN0.
  - LEN0: `byte_ready`=1. A transfer captures len[7:0] → LEN1.
  - LEN1: `byte_ready`=1. A transfer captures len[15:8]. If N==0 or N>2**ADDR_W → ERR. Otherwise → DATA with byte lane = 0 and `imem_waddr`=0.
  - DATA: `byte_ready`=1. Each transfer places the byte into lane `lane` of `imem_wdata` and increments the 2-bit lane counter. The transfer into lane 3 → WRITE.
  - WRITE: `byte_ready`=0 and `imem_we`=1 for exactly one cycle. If `imem_waddr`==N-1 → DONE. Otherwise increment `imem_waddr` → DATA.
  - DONE: `done`=1 and `core_reset_n`=1, held until `start`. `start` → LEN0.
  - ERR: `err`=1 and `core_reset_n`=0, held until `start`. `start` → LEN0.
- **Entering LEN0 from any state** sets `busy`=1, `done`=0, `err`=0 and `core_reset_n`=0.
- **Width rules:**
  - Length compare is done at ADDR_W+1 bits, so N=2**ADDR_W is legal and exactly fills memory.
  - `imem_waddr` never wraps; the last write address is N-1.
- **Boundary conditions:**
  - `start` while `busy`: ignored, with no effect on the transfer in progress.
  - `byte_valid` outside LEN0/LEN1/DATA: byte not consumed, because `byte_ready`=0.
  - Asynchronous `reset` mid-load: all outputs take their reset values immediately. Partial words are discarded, no further `imem_we` is issued, and the core stays in reset.
  - Bytes beyond the 4N payload are not consumed. `byte_ready` is 0 in DONE.

## Timing

- Registered outputs. `imem_we`/`imem_waddr`/`imem_wdata` are valid in the same cycle.
- `start` sampled at edge t → LEN0 from edge t, so `byte_ready`=1 in cycle t+1.
- Cost per word, with valid continuously high:
  - 4 byte cycles + 1 WRITE cycle = 5 cycles per word.
  - A full load is 2 + 5N cycles from the first ready cycle to entering DONE.
- `core_reset_n` rises in the same cycle `done` rises, i.e. the cycle after the final `imem_we`.
- The source may stall arbitrarily. State holds and nothing times out.

## Structure

- **Shared package:**
  - State enum (IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR).
  - Constant `HDR_BYTES`=2.
  - Constant `WORD_BYTES`=4.
- **Sub-module `word_assembler`:** 2-bit lane counter plus 32-bit lane-write register, with `clear`, `push` and `byte_in` inputs and `word`/`full` outputs. The FSM sequences it and owns the address counter and length register.

## Test plan

1. **Reset:** hold `reset`=0 with random inputs → all outputs 0, and `byte_ready`=0 throughout.
2. **Basic load:** `start`, then bytes 02 00 13 05 10 00 93 05 20 00 with continuous valid →
   - `imem_we` at addr 0 with 0x00100513, then at addr 1 with 0x00200593.
   - `done`=1 and `core_reset_n`=1 twelve cycles after the first ready cycle.
3. **Stalled stream:** same stream with random `byte_valid` gaps → identical writes. `byte_ready`=0 in every WRITE cycle, and no byte is lost or duplicated.
4. **Illegal length:**
   - N=0 → `err`=1, no `imem_we`.
   - N=257 with ADDR_W=8 → `err`=1.
   - N=256 → 256 writes, addr 0..255, then `done`=1.
5. **Reset mid-load:** `reset` low after 5 bytes accepted → outputs at reset values at once, no further writes. A new `start` with the stream from test 2 then loads correctly.
6. **Start handling:**
   - `start` pulsed while `busy` → ignored.
   - `start` in DONE → `core_reset_n`=0 and `done`=0 the next cycle, and a new load proceeds from addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StWrite,
    StDone,
    StErr
  } state_e;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake, instruction-memory write port and core-control signals of the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();

  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_reset_n;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata, core_reset_n, busy, done, err
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata, core_reset_n, busy, done, err
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian bytes into a 32-bit word; full flags that the next push completes it.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  localparam int unsigned LANE_W = $clog2(WORD_BYTES);

  logic [LANE_W-1:0] r_lane;
  logic [31:0]       r_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (clear) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (push) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (r_lane == LANE_W'(i)) r_word[8*i +: 8] <= byte_in;
      end
      // Wraps to lane 0 after the last lane, ready for the next word.
      r_lane <= r_lane + 1'b1;
    end
  end

  assign word = r_word;
  assign full = (r_lane == LANE_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader: fills instruction memory and holds the core in reset
// until the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_e            r_state;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_last;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_core_rst_n;

  logic        w_ready;
  logic        w_xfer;
  logic [15:0] w_len;
  logic [31:0] w_word;
  logic        w_full;

  always_comb begin
    w_ready = (r_state == StLen0) || (r_state == StLen1) || (r_state == StData);
  end

  assign w_xfer = bus.byte_valid & w_ready;
  assign w_len  = {bus.byte_data, r_len_lo};

  imem_loader_word_assembler u_word_assembler (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_xfer && (r_state == StLen1)),
    .push    (w_xfer && (r_state == StData)),
    .byte_in (bus.byte_data),
    .word    (w_word),
    .full    (w_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_len_lo     <= '0;
      r_last       <= '0;
      r_waddr      <= '0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        StIdle, StDone, StErr: begin
          if (bus.start) begin
            r_state      <= StLen0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b0;
          end
        end
        StLen0: begin
          if (w_xfer) begin
            r_len_lo <= bus.byte_data;
            r_state  <= StLen1;
          end
        end
        StLen1: begin
          if (w_xfer) begin
            // Compared one bit wider than the address so a full-memory load is legal.
            if ((w_len == '0) || ({1'b0, w_len} > MAX_WORDS)) begin
              r_state <= StErr;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_last  <= w_len - 16'd1;
              r_waddr <= '0;
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (w_xfer && w_full) begin
            r_state <= StWrite;
            r_we    <= 1'b1;
          end
        end
        StWrite: begin
          if (16'(r_waddr) == r_last) begin
            r_state      <= StDone;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_core_rst_n <= 1'b1;
          end else begin
            r_waddr <= r_waddr + 1'b1;
            r_state <= StData;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.byte_ready   = w_ready;
  assign bus.imem_we      = r_we;
  assign bus.imem_waddr   = r_waddr;
  assign bus.imem_wdata   = w_word;
  assign bus.core_reset_n = r_core_rst_n;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;

endmodule
